// File: rtl/boreal_ledger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boreal_ledger_pkg
// Brief    : Ledger slave register map, error codes and entry geometry.
// Revision : 1.0
// ============================================================================
package boreal_ledger_pkg;

    localparam int unsigned c_WORD_W       = 32;
    localparam int unsigned c_DEF_RD_WORDS = 4;
    localparam int unsigned c_ENTRY_W      = c_WORD_W * c_DEF_RD_WORDS;

    localparam logic [31:0] c_OFF_IDX      = 32'h00;
    localparam logic [31:0] c_OFF_DEPTH    = 32'h04;
    localparam logic [31:0] c_OFF_RD_ADDR  = 32'h08;
    localparam logic [31:0] c_OFF_RD_DATA0 = 32'h0C;

    localparam logic [2:0] c_ERR_OK      = 3'd0;
    localparam logic [2:0] c_ERR_RANGE   = 3'd1;
    localparam logic [2:0] c_ERR_STALE   = 3'd2;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] c_ERR_ABORT   = 3'd4;

    function automatic logic [31:0] word_offset(input logic [7:0] k);
        return c_OFF_RD_DATA0 + {22'd0, k, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/boreal_mmio_master_port.sv
`default_nettype none
// ============================================================================
// Module   : boreal_mmio_master_port
// Brief    : Single-access MMIO sequencer: holds sel/addr/wr/wdata until ack,
//            gives up after ACK_TIMEOUT unacknowledged cycles.
// Revision : 1.0
// ============================================================================
module boreal_mmio_master_port #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_cancel,
    output logic        o_access_done,
    output logic        o_timeout,
    output logic [31:0] o_rdata,
    output logic        o_m_sel,
    output logic        o_m_wr,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    input  logic [31:0] i_m_rdata,
    input  logic        i_m_ack
);

    localparam int unsigned           c_WAIT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(ACK_TIMEOUT - 1);

    logic                r_sel;
    logic                r_wr;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [c_WAIT_W-1:0] r_wait;

    assign o_access_done = r_sel && i_m_ack && !i_cancel;
    assign o_timeout     = r_sel && !i_m_ack && !i_cancel && (r_wait == c_WAIT_LAST);
    assign o_rdata       = i_m_rdata;
    assign o_m_sel       = r_sel;
    assign o_m_wr        = r_wr;
    assign o_m_addr      = r_addr;
    assign o_m_wdata     = r_wdata;

    // A new request may be launched in the same cycle the previous one is acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
        end else if (i_cancel) begin
            r_sel  <= 1'b0;
            r_wait <= '0;
        end else if (i_req) begin
            r_sel   <= 1'b1;
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wait  <= '0;
        end else if (o_access_done || o_timeout) begin
            r_sel <= 1'b0;
        end else if (r_sel) begin
            r_wait <= r_wait + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boreal_ledger_replay.sv
`default_nettype none
// ============================================================================
// Module   : boreal_ledger_replay
// Brief    : Replays a range of committed ledger entries read over MMIO onto
//            a valid/ready stream tagged with the ledger index.
// Revision : 1.0
// ============================================================================
module boreal_ledger_replay
    import boreal_ledger_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned RD_WORDS    = c_DEF_RD_WORDS,
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              start_idx,
    input  logic [31:0]              count,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               err,
    output logic                     m_sel,
    output logic                     m_wr,
    output logic [31:0]              m_addr,
    output logic [31:0]              m_wdata,
    input  logic [31:0]              m_rdata,
    input  logic                     m_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32*RD_WORDS-1:0]   out_data,
    output logic [31:0]              out_index,
    output logic                     out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_IDX, S_CHECK, S_SET_ADDR, S_SETTLE, S_RD_WORD, S_OUT, S_FIN
    } state_e;

    localparam logic [7:0] c_SETTLE = 8'(SETTLE);
    localparam logic [7:0] c_LAST_K = 8'(RD_WORDS - 1);

    state_e                  r_state;
    logic [31:0]             r_start_idx;
    logic [31:0]             r_count;
    logic [31:0]             r_cur_idx;
    logic [31:0]             r_n;
    logic [7:0]              r_k;
    logic [7:0]              r_settle;
    logic                    r_busy;
    logic                    r_done;
    logic [2:0]              r_err;
    logic                    r_out_valid;
    logic [32*RD_WORDS-1:0]  r_out_data;
    logic [31:0]             r_out_index;
    logic                    r_out_last;

    logic        w_req;
    logic        w_wr;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_acc_done;
    logic        w_timeout;
    logic [31:0] w_rdata;
    logic        w_abort;
    logic [31:0] w_span;
    logic        w_range;
    logic        w_stale;
    logic        w_fail;
    logic [2:0]  w_fail_err;

    assign w_abort    = abort && r_busy;
    assign w_span     = r_cur_idx - r_start_idx;
    assign w_range    = (r_start_idx >= r_cur_idx) || (r_count > w_span);
    assign w_stale    = w_span > 32'(DEPTH);
    assign w_fail     = w_timeout || ((r_state == S_CHECK) && (w_range || w_stale));
    assign w_fail_err = w_timeout ? c_ERR_TIMEOUT : (w_range ? c_ERR_RANGE : c_ERR_STALE);

    // Next bus access is decided in the cycle the previous one completes so
    // that back-to-back accesses carry no idle gap.
    always_comb begin
        w_req   = 1'b0;
        w_wr    = 1'b0;
        w_addr  = BASE + c_OFF_IDX;
        w_wdata = '0;
        if (!w_abort) begin
            case (r_state)
                S_IDLE: w_req = start && (count != 32'd0);
                S_CHECK: if (!w_range && !w_stale) begin
                    w_req   = 1'b1;
                    w_wr    = 1'b1;
                    w_addr  = BASE + c_OFF_RD_ADDR;
                    w_wdata = r_start_idx + r_n;
                end
                S_SET_ADDR: if (w_acc_done && (c_SETTLE == 8'd0)) begin
                    w_req  = 1'b1;
                    w_addr = BASE + word_offset(8'd0);
                end
                S_SETTLE: if (r_settle == c_SETTLE) begin
                    w_req  = 1'b1;
                    w_addr = BASE + word_offset(8'd0);
                end
                S_RD_WORD: if (w_acc_done && (r_k != c_LAST_K)) begin
                    w_req  = 1'b1;
                    w_addr = BASE + word_offset(r_k + 8'd1);
                end
                S_OUT: if (out_ready && !r_out_last) begin
                    w_req   = 1'b1;
                    w_wr    = 1'b1;
                    w_addr  = BASE + c_OFF_RD_ADDR;
                    w_wdata = r_start_idx + r_n + 32'd1;
                end
                default: ;
            endcase
        end
    end

    boreal_mmio_master_port #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_port (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (w_req),
        .i_wr          (w_wr),
        .i_addr        (w_addr),
        .i_wdata       (w_wdata),
        .i_cancel      (w_abort),
        .o_access_done (w_acc_done),
        .o_timeout     (w_timeout),
        .o_rdata       (w_rdata),
        .o_m_sel       (m_sel),
        .o_m_wr        (m_wr),
        .o_m_addr      (m_addr),
        .o_m_wdata     (m_wdata),
        .i_m_rdata     (m_rdata),
        .i_m_ack       (m_ack)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start_idx <= '0;
            r_count     <= '0;
            r_cur_idx   <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= c_ERR_OK;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort || w_fail) begin
                r_state     <= S_FIN;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_err       <= w_abort ? c_ERR_ABORT : w_fail_err;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_start_idx <= start_idx;
                        r_count     <= count;
                        r_n         <= '0;
                        r_err       <= c_ERR_OK;
                        if (count == 32'd0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RD_IDX;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RD_IDX: if (w_acc_done) begin
                        r_cur_idx <= w_rdata;
                        r_state   <= S_CHECK;
                    end
                    S_CHECK: r_state <= S_SET_ADDR;
                    S_SET_ADDR: if (w_acc_done) begin
                        r_k      <= '0;
                        r_settle <= 8'd1;
                        r_state  <= (c_SETTLE == 8'd0) ? S_RD_WORD : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle == c_SETTLE) begin
                            r_state <= S_RD_WORD;
                        end else begin
                            r_settle <= r_settle + 8'd1;
                        end
                    end
                    S_RD_WORD: if (w_acc_done) begin
                        r_out_data[c_WORD_W*r_k +: c_WORD_W] <= w_rdata;
                        if (r_k == c_LAST_K) begin
                            r_out_valid <= 1'b1;
                            r_out_index <= r_start_idx + r_n;
                            r_out_last  <= (r_n == r_count - 32'd1);
                            r_state     <= S_OUT;
                        end else begin
                            r_k <= r_k + 8'd1;
                        end
                    end
                    S_OUT: if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_n         <= r_n + 32'd1;
                        if (r_out_last) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SET_ADDR;
                        end
                    end
                    S_FIN: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_boreal_ledger_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_boreal_ledger_replay
// Brief    : Scoreboard bench for boreal_ledger_replay with a ledger slave model.
// Revision : 1.0
// ============================================================================
module tb_boreal_ledger_replay;
    import boreal_ledger_pkg::*;

    localparam int unsigned RD_WORDS = 4;

    typedef struct packed {
        logic [31:0]            idx;
        logic [32*RD_WORDS-1:0] data;
        logic                   last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [31:0]            start_idx = '0;
    logic [31:0]            count = '0;
    logic                   abort = 1'b0;
    logic                   busy, done;
    logic [2:0]             err;
    logic                   m_sel, m_wr, m_ack;
    logic [31:0]            m_addr, m_wdata, m_rdata;
    logic                   out_valid, out_last;
    logic                   out_ready = 1'b1;
    logic [32*RD_WORDS-1:0] out_data;
    logic [31:0]            out_index;

    logic [31:0] ledger_idx = 32'd5;
    logic [31:0] rd_addr = '0;
    logic        stall_k2 = 1'b0;
    int          wr_cnt = 0, acc_cnt = 0, k2_sel_cnt = 0, cyc = 0, start_cyc = 0;
    logic [31:0] last_wdata = '0;
    int          n_checks = 0, n_errors = 0;
    beat_t       exp_q[$];
    int          xfer_cyc[$];

    always #5 clk = ~clk;

    boreal_ledger_replay #(
        .BASE(32'h0), .DEPTH(1024), .RD_WORDS(RD_WORDS), .SETTLE(1), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_idx(start_idx), .count(count),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    function automatic logic [31:0] word_of(input logic [31:0] idx, input int k);
        logic [31:0] a;
        a = idx & 32'd1023;
        return {a[15:0], 8'(k), 8'h5A} ^ 32'hB0DE_0000;
    endfunction

    function automatic logic [32*RD_WORDS-1:0] entry_of(input logic [31:0] idx);
        logic [32*RD_WORDS-1:0] d;
        for (int k = 0; k < RD_WORDS; k++) d[32*k +: 32] = word_of(idx, k);
        return d;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Ledger slave: same-cycle ack, data word k of the entry selected by RD_ADDR.
    assign m_ack = m_sel && !(stall_k2 && !m_wr && (m_addr == 32'h14));
    always_comb begin
        m_rdata = 32'h0;
        if (m_addr == 32'h0) m_rdata = ledger_idx;
        else if (m_addr >= 32'h0C && m_addr <= 32'h18)
            m_rdata = word_of(rd_addr, int'((m_addr - 32'h0C) >> 2));
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_sel && m_ack) acc_cnt <= acc_cnt + 1;
        if (m_sel && m_ack && m_wr && (m_addr == 32'h08)) begin
            rd_addr    <= m_wdata;
            last_wdata <= m_wdata;
            wr_cnt     <= wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_sel && !m_wr && (m_addr == 32'h14)) k2_sel_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", out_valid, 1'b0);
                end else begin
                    check_eq("beat_index", out_index, exp_q[0].idx);
                    check_eq("beat_data", out_data, exp_q[0].data);
                    check_eq("beat_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cyc.push_back(cyc);
                    end else begin
                        check_eq("stall_no_bus", m_sel, 1'b0);
                    end
                end
            end
        end
    end

    task automatic push_beats(input logic [31:0] sidx, input int cnt, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{idx: sidx + 32'(i), data: entry_of(sidx + 32'(i)), last: (i == cnt - 1)});
    endtask

    task automatic do_cmd(input logic [31:0] sidx, input logic [31:0] cnt, input logic with_abort);
        @(posedge clk); #1;
        start = 1'b1; start_idx = sidx; count = cnt; abort = with_abort;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [2:0] exp_err);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 500);
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_err"}, err, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {busy, done, err}, '0);
        check_eq({tag, "_bus"}, {m_sel, m_wr, m_addr, m_wdata}, '0);
        check_eq({tag, "_stream"}, {out_valid, out_last, out_index}, '0);
        check_eq({tag, "_data"}, out_data, '0);
    endtask

    initial begin
        int n;
        int base_wr, base_acc;
        #1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: three entries, latency and last flag
        ledger_idx = 32'd5;
        xfer_cyc.delete();
        push_beats(32'd1, 3, 3);
        do_cmd(32'd1, 32'd3, 1'b0);
        wait_done("t1", c_ERR_OK);
        check_eq("t1_beats", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check_eq("t1_first_latency", xfer_cyc[0] - start_cyc, 9);
            check_eq("t1_next_latency", xfer_cyc[1] - xfer_cyc[0], 7);
        end
        check_eq("t1_queue_empty", exp_q.size(), 0);

        // 2: range errors and empty command
        base_wr = wr_cnt;
        do_cmd(32'd5, 32'd1, 1'b0);
        wait_done("t2a", c_ERR_RANGE);
        check_eq("t2a_no_rd_addr", wr_cnt - base_wr, 0);
        do_cmd(32'd2, 32'd4, 1'b0);
        wait_done("t2b", c_ERR_RANGE);
        base_acc = acc_cnt;
        do_cmd(32'd1, 32'd0, 1'b0);
        wait_done("t2c", c_ERR_OK);
        check_eq("t2c_no_bus", acc_cnt - base_acc, 0);

        // 3: stale entry, then a valid one at the depth boundary (abort with start ignored)
        ledger_idx = 32'd1030;
        do_cmd(32'd2, 32'd1, 1'b0);
        wait_done("t3a", c_ERR_STALE);
        push_beats(32'd6, 1, 1);
        do_cmd(32'd6, 32'd1, 1'b1);
        wait_done("t3b", c_ERR_OK);
        check_eq("t3b_rd_addr", last_wdata, 32'd6);
        check_eq("t3b_queue_empty", exp_q.size(), 0);

        // 4: back-pressure on beat 2
        ledger_idx = 32'd5;
        push_beats(32'd1, 3, 3);
        do_cmd(32'd1, 32'd3, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_index == 32'd1) && n < 100);
        check_eq("t4_beat1_seen", out_valid, 1'b1);
        @(posedge clk); #1 out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        for (int i = 0; i < 10; i++) begin
            check_eq("t4_hold_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("t4", c_ERR_OK);
        check_eq("t4_queue_empty", exp_q.size(), 0);

        // 5: ack withheld on word 2
        stall_k2 = 1'b1;
        k2_sel_cnt = 0;
        do_cmd(32'd1, 32'd1, 1'b0);
        wait_done("t5", c_ERR_TIMEOUT);
        check_eq("t5_sel_cycles", k2_sel_cnt, 16);
        check_eq("t5_sel_dropped", m_sel, 1'b0);
        stall_k2 = 1'b0;

        // 6: abort in SETTLE of entry 2, then a clean replay
        push_beats(32'd1, 3, 1);
        do_cmd(32'd1, 32'd3, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(m_sel && m_wr && m_addr == 32'h08 && m_wdata == 32'd2) && n < 100);
        check_eq("t6_second_set_addr", m_wdata, 32'd2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_eq("t6_sel_low", m_sel, 1'b0);
        check_eq("t6_valid_low", out_valid, 1'b0);
        check_eq("t6_done", done, 1'b1);
        check_eq("t6_err", err, c_ERR_ABORT);
        check_eq("t6_queue_empty", exp_q.size(), 0);
        push_beats(32'd1, 2, 2);
        do_cmd(32'd1, 32'd2, 1'b0);
        wait_done("t6r", c_ERR_OK);
        check_eq("t6r_queue_empty", exp_q.size(), 0);

        // 7: reset pulse mid-RD_WORD
        push_beats(32'd1, 1, 1);
        do_cmd(32'd1, 32'd1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(m_sel && !m_wr && m_addr == 32'h10) && n < 100);
        check_eq("t7_in_rd_word", m_addr, 32'h10);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("t7_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t7_no_done", {done, busy}, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
